waveform_to_pipe: RTL

- Host-bound counterpart of the pipe-fed stimulus path: captures 32-bit simulation samples (e.g. Ia_fr, II_fr, current_lce) on a sample strobe.
- Splits each sample into 16-bit words, buffers them in a synchronous FIFO, and presents them to a block-throttled pipe-out endpoint (ep_read / ep_ready / ep_datain).
- Sits between the spindle/neuron outputs and okBTPipeOut in the top level, in the ti_clk domain; strobes arrive already synchronised.

---
 rtl/waveform_pipe_pkg.sv | 25 ++
 rtl/waveform_to_pipe_if.sv | 26 ++
 rtl/waveform_to_pipe_fifo.sv | 73 +++++++
 rtl/waveform_to_pipe.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/waveform_pipe_pkg.sv
// Shared types and constants for the waveform-to-pipe capture path.
// Build option: WAVEFORM_TO_PIPE_TIMESTAMP_EN prepends a 16-bit sample counter word.
package waveform_pipe_pkg;

`ifdef WAVEFORM_TO_PIPE_TIMESTAMP_EN
  localparam int WPS = 3;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WR_TS = 2'd1,
    WR0   = 2'd2,
    WR1   = 2'd3
  } wr_state_e;
`else
  localparam int WPS = 2;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR0  = 2'd2,
    WR1  = 2'd3
  } wr_state_e;
`endif

  localparam logic [15:0] DROP_MAX   = 16'hFFFF;
  localparam logic [15:0] EMPTY_WORD = 16'h0000;

endpackage

// File: rtl/waveform_to_pipe_if.sv
// Sample-capture and pipe-out signals of waveform_to_pipe.
// master = host/stimulus side, slave = the capture block.
interface waveform_to_pipe_if #(
  parameter int ADDR_W = 10
);
  logic            clear;
  logic            enable;
  logic            sample_strobe;
  logic [31:0]     sample_data;
  logic            ep_read;
  logic [15:0]     ep_datain;
  logic            ep_ready;
  logic [ADDR_W:0] fill_level;
  logic [15:0]     drop_count;
  logic            underflow;

  modport master (
    output clear, enable, sample_strobe, sample_data, ep_read,
    input  ep_datain, ep_ready, fill_level, drop_count, underflow
  );

  modport slave (
    input  clear, enable, sample_strobe, sample_data, ep_read,
    output ep_datain, ep_ready, fill_level, drop_count, underflow
  );
endinterface

// File: rtl/waveform_to_pipe_fifo.sv
// pipe_fifo_sync: single-clock first-word-fall-through FIFO of 16-bit words.
// Head word comes from a registered RAM read, with a bypass for a word written straight into the head slot.
module pipe_fifo_sync
  import waveform_pipe_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clear_i,
  input  logic            wr_en_i,
  input  logic [15:0]     din_i,
  input  logic            rd_en_i,
  output logic [15:0]     dout_o,
  output logic [ADDR_W:0] count_o,
  output logic            empty_o
);
  localparam int DEPTH = 1 << ADDR_W;

  logic [15:0]       mem [DEPTH];
  logic [15:0]       ram_q;
  logic [15:0]       byp_q;
  logic              byp_sel_q;
  logic [ADDR_W-1:0] wr_ptr_q;
  logic [ADDR_W-1:0] rd_ptr_q;
  logic [ADDR_W-1:0] rd_ptr_d;
  logic [ADDR_W:0]   count_q;
  logic [ADDR_W:0]   count_d;
  logic              do_wr;
  logic              do_rd;

  assign empty_o  = (count_q == '0);
  assign do_wr    = wr_en_i && !count_q[ADDR_W];
  assign do_rd    = rd_en_i && !empty_o;
  assign rd_ptr_d = rd_ptr_q + ADDR_W'(do_rd);
  assign count_d  = count_q + (ADDR_W+1)'(do_wr) - (ADDR_W+1)'(do_rd);

  // RAM read is addressed by the next head pointer so the new head is ready one cycle after a pop.
  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wr_ptr_q] <= din_i;
    end
    ram_q <= mem[rd_ptr_d];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      byp_q     <= '0;
      byp_sel_q <= 1'b0;
    end else if (clear_i) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      byp_q     <= '0;
      byp_sel_q <= 1'b0;
    end else begin
      if (do_wr) begin
        wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
      end
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      byp_sel_q <= do_wr && (wr_ptr_q == rd_ptr_d);
      byp_q     <= din_i;
    end
  end

  assign count_o = count_q;
  assign dout_o  = empty_o ? EMPTY_WORD : (byp_sel_q ? byp_q : ram_q);

endmodule

// File: rtl/waveform_to_pipe.sv
// Captures 32-bit samples on a strobe, splits them into 16-bit words (low half first) and
// queues them for a block-throttled pipe-out. Option: WAVEFORM_TO_PIPE_TIMESTAMP_EN.
module waveform_to_pipe
  import waveform_pipe_pkg::*;
#(
  parameter int ADDR_W      = 10,
  parameter int BLOCK_WORDS = 256
) (
  input logic               clk,
  input logic               reset,
  waveform_to_pipe_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] FREE_LIMIT = (ADDR_W+1)'(DEPTH - WPS);
  localparam logic [ADDR_W:0] BLOCK_LVL  = (ADDR_W+1)'(BLOCK_WORDS);
`ifdef WAVEFORM_TO_PIPE_TIMESTAMP_EN
  localparam wr_state_e FIRST_WR = WR_TS;
`else
  localparam wr_state_e FIRST_WR = WR0;
`endif

  wr_state_e       state_q;
  wr_state_e       state_d;
  logic [31:0]     hold_q;
  logic [15:0]     drop_q;
  logic            under_q;
  logic            ready_q;
  logic            wr_en;
  logic [15:0]     wr_data;
  logic [ADDR_W:0] fifo_count;
  logic            fifo_empty;
  logic [15:0]     fifo_dout;
  logic            strobe_en;
  logic            accept;
  logic            drop;

  assign strobe_en = bus.sample_strobe && bus.enable;
  // Only a full sample's worth of space admits a capture, so partial samples never reach the FIFO.
  assign accept    = strobe_en && (state_q == IDLE) && (fifo_count <= FREE_LIMIT);
  assign drop      = strobe_en && !accept;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (bus.clear) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (accept) state_d = FIRST_WR;
`ifdef WAVEFORM_TO_PIPE_TIMESTAMP_EN
        WR_TS:   state_d = WR0;
`endif
        WR0:     state_d = WR1;
        WR1:     state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

`ifdef WAVEFORM_TO_PIPE_TIMESTAMP_EN
  logic [15:0] ts_q;
  logic [15:0] ts_hold_q;

  // Counts every enabled strobe, dropped or not, so gaps are visible to the host.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ts_q      <= '0;
      ts_hold_q <= '0;
    end else if (bus.clear) begin
      ts_q      <= '0;
      ts_hold_q <= '0;
    end else if (strobe_en) begin
      ts_q <= ts_q + 16'd1;
      if (accept) begin
        ts_hold_q <= ts_q;
      end
    end
  end
`endif

  always_comb begin
    wr_en   = 1'b0;
    wr_data = '0;
    case (state_q)
`ifdef WAVEFORM_TO_PIPE_TIMESTAMP_EN
      WR_TS: begin
        wr_en   = 1'b1;
        wr_data = ts_hold_q;
      end
`endif
      WR0: begin
        wr_en   = 1'b1;
        wr_data = hold_q[15:0];
      end
      WR1: begin
        wr_en   = 1'b1;
        wr_data = hold_q[31:16];
      end
      default: begin
        wr_en   = 1'b0;
        wr_data = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_q  <= '0;
      drop_q  <= '0;
      under_q <= 1'b0;
      ready_q <= 1'b0;
    end else if (bus.clear) begin
      hold_q  <= '0;
      drop_q  <= '0;
      under_q <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      if (accept) begin
        hold_q <= bus.sample_data;
      end
      if (drop && (drop_q != DROP_MAX)) begin
        drop_q <= drop_q + 16'd1;
      end
      if (bus.ep_read && fifo_empty) begin
        under_q <= 1'b1;
      end
      ready_q <= (fifo_count >= BLOCK_LVL);
    end
  end

  pipe_fifo_sync #(
    .ADDR_W(ADDR_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (reset),
    .clear_i (bus.clear),
    .wr_en_i (wr_en),
    .din_i   (wr_data),
    .rd_en_i (bus.ep_read),
    .dout_o  (fifo_dout),
    .count_o (fifo_count),
    .empty_o (fifo_empty)
  );

  assign bus.ep_datain  = fifo_dout;
  assign bus.ep_ready   = ready_q;
  assign bus.fill_level = fifo_count;
  assign bus.drop_count = drop_q;
  assign bus.underflow  = under_q;

endmodule
